// File: rtl/logic_axi4_lite_pkg.sv
`default_nettype none
// ============================================================================
// logic_axi4_lite_pkg : shared response codes, write-FSM states, address decode
// Rev 1.0 - initial release
// ============================================================================
package logic_axi4_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'd0,
    EXOKAY = 2'd1,
    SLVERR = 2'd2,
    DECERR = 2'd3
  } response_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HAVE_AW = 2'd1,
    HAVE_W  = 2'd2,
    RESP    = 2'd3
  } write_state_t;

  // Word index of a byte address; the sub-word byte offset is discarded.
  function automatic logic [31:0] index(input logic [31:0] addr, input int data_bytes);
    int shift;
    shift = 0;
    for (int s = 0; s < 31; s++) begin
      if ((1 << s) == data_bytes) shift = s;
    end
    return addr >> shift;
  endfunction

endpackage
`default_nettype wire

// File: rtl/logic_axi4_lite_register_slave_write.sv
`default_nettype none
// ============================================================================
// logic_axi4_lite_register_slave_write : AW/W join FSM and B channel
// Rev 1.0 - initial release
// ============================================================================
module logic_axi4_lite_register_slave_write
  import logic_axi4_lite_pkg::*;
#(
  parameter int DATA_BYTES    = 4,
  parameter int ADDRESS_WIDTH = 8,
  parameter int REGISTERS     = 16,
  parameter int INDEX_WIDTH   = (REGISTERS > 1) ? $clog2(REGISTERS) : 1
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     awvalid,
  output logic                     awready,
  input  logic [ADDRESS_WIDTH-1:0] awaddr,
  input  logic                     wvalid,
  output logic                     wready,
  input  logic [DATA_BYTES*8-1:0]  wdata,
  input  logic [DATA_BYTES-1:0]    wstrb,
  output logic                     bvalid,
  input  logic                     bready,
  output response_t                bresp,
  output logic                     commit,
  output logic                     commit_in_range,
  output logic [INDEX_WIDTH-1:0]   commit_index,
  output logic [DATA_BYTES*8-1:0]  commit_data,
  output logic [DATA_BYTES-1:0]    commit_strb
);

  write_state_t state, state_next;
  logic [ADDRESS_WIDTH-1:0] aw_addr_q;
  logic [DATA_BYTES*8-1:0]  w_data_q;
  logic [DATA_BYTES-1:0]    w_strb_q;
  logic                     aw_hs, w_hs;
  logic [ADDRESS_WIDTH-1:0] commit_addr;
  logic [31:0]              commit_index_full;

  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid & wready;

  // A beat that arrived earlier comes from its holding register, the other from the bus.
  assign commit_addr       = (state == HAVE_AW) ? aw_addr_q : awaddr;
  assign commit_data       = (state == HAVE_W) ? w_data_q : wdata;
  assign commit_strb       = (state == HAVE_W) ? w_strb_q : wstrb;
  assign commit_index_full = index(32'(commit_addr), DATA_BYTES);
  assign commit_in_range   = commit_index_full < 32'(REGISTERS);
  assign commit_index      = INDEX_WIDTH'(commit_index_full);

  always_comb begin
    state_next = state;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (aw_hs && w_hs) begin
          commit     = 1'b1;
          state_next = RESP;
        end else if (aw_hs) begin
          state_next = HAVE_AW;
        end else if (w_hs) begin
          state_next = HAVE_W;
        end
      end
      HAVE_AW: if (w_hs) begin
        commit     = 1'b1;
        state_next = RESP;
      end
      HAVE_W: if (aw_hs) begin
        commit     = 1'b1;
        state_next = RESP;
      end
      RESP:    if (bready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state   <= IDLE;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= OKAY;
    end else begin
      state   <= state_next;
      awready <= (state_next == IDLE) || (state_next == HAVE_W);
      wready  <= (state_next == IDLE) || (state_next == HAVE_AW);
      bvalid  <= (state_next == RESP);
      if (commit) bresp <= commit_in_range ? OKAY : SLVERR;
    end
  end

  always_ff @(posedge aclk) begin
    if (aw_hs) aw_addr_q <= awaddr;
    if (w_hs) begin
      w_data_q <= wdata;
      w_strb_q <= wstrb;
    end
  end

endmodule
`default_nettype wire

// File: rtl/logic_axi4_lite_register_slave.sv
`default_nettype none
// ============================================================================
// logic_axi4_lite_register_slave : AXI4-Lite slave exporting a register bank
// Rev 1.0 - initial release
// ============================================================================
module logic_axi4_lite_register_slave
  import logic_axi4_lite_pkg::*;
#(
  parameter int                      DATA_BYTES    = 4,
  parameter int                      ADDRESS_WIDTH = 8,
  parameter int                      REGISTERS     = 16,
  parameter logic [DATA_BYTES*8-1:0] RESET_VALUE   = '0
) (
  input  logic                                aclk,
  input  logic                                areset,
  input  logic                                awvalid,
  output logic                                awready,
  input  logic [ADDRESS_WIDTH-1:0]            awaddr,
  input  logic [2:0]                          awprot,
  input  logic                                wvalid,
  output logic                                wready,
  input  logic [DATA_BYTES*8-1:0]             wdata,
  input  logic [DATA_BYTES-1:0]               wstrb,
  output logic                                bvalid,
  input  logic                                bready,
  output response_t                           bresp,
  input  logic                                arvalid,
  output logic                                arready,
  input  logic [ADDRESS_WIDTH-1:0]            araddr,
  input  logic [2:0]                          arprot,
  output logic                                rvalid,
  input  logic                                rready,
  output logic [DATA_BYTES*8-1:0]             rdata,
  output response_t                           rresp,
  output logic [REGISTERS*DATA_BYTES*8-1:0]   registers,
  output logic [REGISTERS-1:0]                written
);

  localparam int DATA_WIDTH  = DATA_BYTES * 8;
  localparam int INDEX_WIDTH = (REGISTERS > 1) ? $clog2(REGISTERS) : 1;

  logic [REGISTERS-1:0][DATA_WIDTH-1:0] words;
  logic                   commit, commit_in_range;
  logic [INDEX_WIDTH-1:0] commit_index;
  logic [DATA_WIDTH-1:0]  commit_data;
  logic [DATA_BYTES-1:0]  commit_strb;
  logic                   unused_prot;

  assign unused_prot = ^{awprot, arprot};
  assign registers   = words;

  logic_axi4_lite_register_slave_write #(
    .DATA_BYTES    (DATA_BYTES),
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .REGISTERS     (REGISTERS),
    .INDEX_WIDTH   (INDEX_WIDTH)
  ) u_write (
    .aclk            (aclk),
    .areset          (areset),
    .awvalid         (awvalid),
    .awready         (awready),
    .awaddr          (awaddr),
    .wvalid          (wvalid),
    .wready          (wready),
    .wdata           (wdata),
    .wstrb           (wstrb),
    .bvalid          (bvalid),
    .bready          (bready),
    .bresp           (bresp),
    .commit          (commit),
    .commit_in_range (commit_in_range),
    .commit_index    (commit_index),
    .commit_data     (commit_data),
    .commit_strb     (commit_strb)
  );

  always_ff @(posedge aclk) begin
    if (areset) begin
      words   <= {REGISTERS{RESET_VALUE}};
      written <= '0;
    end else begin
      written <= '0;
      if (commit && commit_in_range) begin
        written[commit_index] <= 1'b1;
        for (int b = 0; b < DATA_BYTES; b++) begin
          if (commit_strb[b]) words[commit_index][b*8 +: 8] <= commit_data[b*8 +: 8];
        end
      end
    end
  end

  logic [31:0]           rd_index_full;
  logic                  rd_in_range;
  logic [DATA_WIDTH-1:0] rd_word;
  response_t             rd_resp;
  logic                  ar_hs, r_free, rvalid_next, skid_next;
  logic                  skid_valid;
  logic [DATA_WIDTH-1:0] skid_data;
  response_t             skid_resp;

  // The read samples the bank before any same-edge write lands.
  assign rd_index_full = index(32'(araddr), DATA_BYTES);
  assign rd_in_range   = rd_index_full < 32'(REGISTERS);
  assign rd_word       = rd_in_range ? words[INDEX_WIDTH'(rd_index_full)] : '0;
  assign rd_resp       = rd_in_range ? OKAY : SLVERR;

  // arready is registered, so a request can land just as R stalls; the skid slot absorbs it.
  assign ar_hs       = arvalid & arready;
  assign r_free      = ~rvalid | rready;
  assign rvalid_next = r_free ? (skid_valid | ar_hs) : 1'b1;
  assign skid_next   = ~r_free & (skid_valid | ar_hs);

  always_ff @(posedge aclk) begin
    if (areset) begin
      rvalid     <= 1'b0;
      rdata      <= '0;
      rresp      <= OKAY;
      arready    <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      if (r_free) begin
        if (skid_valid) begin
          rdata <= skid_data;
          rresp <= skid_resp;
        end else if (ar_hs) begin
          rdata <= rd_word;
          rresp <= rd_resp;
        end
      end
      rvalid     <= rvalid_next;
      skid_valid <= skid_next;
      arready    <= ~skid_next & (~rvalid_next | rready);
    end
  end

  always_ff @(posedge aclk) begin
    if (ar_hs && !r_free) begin
      skid_data <= rd_word;
      skid_resp <= rd_resp;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_logic_axi4_lite_register_slave.sv
`default_nettype none
// ============================================================================
// tb_logic_axi4_lite_register_slave : directed self-checking bench
// Rev 1.0 - initial release
// ============================================================================
module tb_logic_axi4_lite_register_slave;

  logic         aclk, areset;
  logic         awvalid, awready, wvalid, wready, bvalid, bready;
  logic         arvalid, arready, rvalid, rready;
  logic [7:0]   awaddr, araddr;
  logic [2:0]   awprot, arprot;
  logic [31:0]  wdata, rdata;
  logic [3:0]   wstrb;
  logic [1:0]   bresp, rresp;
  logic [511:0] registers;
  logic [15:0]  written;

  logic [31:0] model [16];
  int n_checks = 0;
  int n_fail   = 0;

  logic_axi4_lite_register_slave dut (
    .aclk(aclk), .areset(areset),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .registers(registers), .written(written)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word(input int i);
    return registers[i*32 +: 32];
  endfunction

  task automatic tick();
    @(posedge aclk);
    @(negedge aclk);
  endtask

  task automatic apply(input int idx, input logic [31:0] data, input logic [3:0] strb);
    if (idx < 16)
      for (int b = 0; b < 4; b++) if (strb[b]) model[idx][b*8 +: 8] = data[b*8 +: 8];
  endtask

  task automatic check_bank(input string tag);
    for (int i = 0; i < 16; i++) check($sformatf("%s_word%0d", tag, i), word(i), model[i]);
  endtask

  // Called at the sample point right after the commit edge.
  task automatic finish_write(input int idx, input int hold);
    logic [1:0] exp_resp;
    exp_resp = (idx < 16) ? 2'd0 : 2'd2;
    check("b_valid", bvalid, 1);
    check("b_resp", bresp, exp_resp);
    check("written_pulse", written, (idx < 16) ? (16'h1 << idx) : 16'h0);
    check("awready_in_resp", awready, 0);
    if (idx < 16) check("word_after_write", word(idx), model[idx]);
    for (int c = 0; c < hold; c++) begin
      tick();
      check("b_hold_valid", bvalid, 1);
      check("b_hold_resp", bresp, exp_resp);
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check("b_done", bvalid, 0);
    check("written_clear", written, 0);
    check("awready_back", awready, 1);
  endtask

  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb);
    awvalid = 1'b1; wvalid = 1'b1; awaddr = addr; wdata = data; wstrb = strb;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    apply(int'(addr >> 2), data, strb);
    finish_write(int'(addr >> 2), 0);
  endtask

  task automatic axi_read(input logic [7:0] addr, input logic [31:0] exp_data, input logic [1:0] exp_resp);
    arvalid = 1'b1; araddr = addr; rready = 1'b1;
    tick();
    arvalid = 1'b0;
    check("r_valid", rvalid, 1);
    check("r_data", rdata, exp_data);
    check("r_resp", rresp, exp_resp);
    tick();
    check("r_done", rvalid, 0);
    rready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    areset = 1'b1; awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0; awprot = 3'b010; arprot = 3'b101;
    for (int i = 0; i < 16; i++) model[i] = 32'h0;
    @(negedge aclk);
    tick(); tick();

    // Reset state
    check("rst_awready", awready, 0);
    check("rst_wready", wready, 0);
    check("rst_arready", arready, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_written", written, 0);
    areset = 1'b0;
    tick();
    check("rel_awready", awready, 1);
    check("rel_wready", wready, 1);
    check("rel_arready", arready, 1);

    // Reset in the middle of a write whose AW was already accepted
    awvalid = 1'b1; awaddr = 8'h0C;
    tick();
    awvalid = 1'b0;
    check("aw_only_awready", awready, 0);
    check("aw_only_wready", wready, 1);
    areset = 1'b1; wvalid = 1'b1; wdata = 32'h12345678; wstrb = 4'hF;
    repeat (3) tick();
    wvalid = 1'b0;
    check("midrst_awready", awready, 0);
    check("midrst_wready", wready, 0);
    check("midrst_bvalid", bvalid, 0);
    areset = 1'b0;
    tick();
    check("postrst_bvalid", bvalid, 0);
    check("postrst_awready", awready, 1);
    check("postrst_wready", wready, 1);
    check("postrst_written", written, 0);
    check_bank("postrst");

    // AW and W together
    axi_write(8'h08, 32'hDEADBEEF, 4'hF);
    check("t2_word2", word(2), 32'hDEADBEEF);

    // W first, AW three cycles later, response held under backpressure
    wvalid = 1'b1; wdata = 32'h000000AA; wstrb = 4'b0001;
    tick();
    wvalid = 1'b0;
    check("w_only_wready", wready, 0);
    check("w_only_awready", awready, 1);
    check("w_only_bvalid", bvalid, 0);
    tick(); tick();
    awvalid = 1'b1; awaddr = 8'h08;
    tick();
    awvalid = 1'b0;
    check("t3_word2", word(2), 32'hDEADBEAA);
    apply(2, 32'h000000AA, 4'b0001);
    finish_write(2, 5);

    // Read stalled by rready low
    arvalid = 1'b1; araddr = 8'h08; rready = 1'b0;
    tick();
    arvalid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check("stall_rvalid", rvalid, 1);
      check("stall_rdata", rdata, 32'hDEADBEAA);
      check("stall_rresp", rresp, 0);
      check("stall_arready", arready, 0);
      if (c < 3) tick();
    end
    rready = 1'b1;
    tick();
    check("stall_done_rvalid", rvalid, 0);
    check("stall_done_arready", arready, 1);
    rready = 1'b0;

    // Fill words for back-to-back reads; strobe 0 leaves word 7 untouched but pulses
    for (int i = 0; i < 8; i++)
      if (i != 2) axi_write(8'(i * 4), 32'hC0DE0000 | 32'(i), 4'hF);
    axi_write(8'h1C, 32'hFFFFFFFF, 4'h0);
    check("strb0_word7", word(7), 32'hC0DE0007);
    axi_write(8'h04, 32'h00AB0000, 4'b0100);
    check("strb2_word1", word(1), 32'hC0AB0001);

    rready = 1'b1; arvalid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      araddr = 8'(i * 4);
      tick();
      check("b2b_rvalid", rvalid, 1);
      check($sformatf("b2b_rdata%0d", i), rdata, model[i]);
      check("b2b_arready", arready, 1);
    end
    arvalid = 1'b0;
    tick();
    check("b2b_end_rvalid", rvalid, 0);
    rready = 1'b0;

    // Out of range accesses
    axi_write(8'h40, 32'hFFFFFFFF, 4'hF);
    check_bank("oor");
    axi_read(8'h44, 32'h0, 2'd2);

    // Same-cycle write and read of word 5
    axi_write(8'h14, 32'h11111111, 4'hF);
    awvalid = 1'b1; wvalid = 1'b1; awaddr = 8'h14; wdata = 32'h22222222; wstrb = 4'hF;
    arvalid = 1'b1; araddr = 8'h14; rready = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    check("rw_rvalid", rvalid, 1);
    check("rw_rdata_old", rdata, 32'h11111111);
    apply(5, 32'h22222222, 4'hF);
    finish_write(5, 0);
    rready = 1'b0;
    axi_read(8'h14, 32'h22222222, 2'd0);
    axi_read(8'h15, 32'h22222222, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
